// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 18-bit address / 16-bit data memory port among N
// bus masters. It runs one transfer at a time, registers every slave-side
// output, and aborts transfers through a watchdog when the memory never acks.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest requesting index wins. Without it, arbitration is round-robin.
module mem_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           m_req,
  input  logic [N*18-1:0]        m_adr,
  input  logic [N-1:0]           m_write,
  input  logic [N*2-1:0]         m_sel,
  input  logic [N*16-1:0]        m_wdata,
  output logic [N-1:0]           m_ack,
  output logic [N-1:0]           m_err,
  output logic [15:0]            m_rdata,
  output logic                   s_req,
  output logic [17:0]            s_adr,
  output logic                   s_write,
  output logic [1:0]             s_sel,
  output logic [15:0]            s_wdata,
  input  logic                   s_ack,
  input  logic [15:0]            s_rdata,
  output logic [$clog2(N)-1:0]   grant,
  output logic                   busy
);

  localparam int GW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [GW-1:0] ptr_r, ptr_s, nxt_ptr_s;
  logic [GW-1:0] grant_r, grant_s;
  logic [15:0]   wd_cnt_r, wd_cnt_s, wd_inc_s;
  logic          s_req_r, s_req_s, s_write_r, s_write_s, busy_r;
  logic [17:0]   s_adr_r, s_adr_s;
  logic [1:0]    s_sel_r, s_sel_s;
  logic [15:0]   s_wdata_r, s_wdata_s;
  logic [N-1:0]  m_err_r, m_err_s;
  logic          win_found_s;
  logic [GW-1:0] win_idx_s;
  logic [17:0]   adr_a_s   [N];
  logic          write_a_s [N];
  logic [1:0]    sel_a_s   [N];
  logic [15:0]   wdata_a_s [N];

  // Split the flat master buses into per-master lanes
  always_comb begin
    for (int i = 0; i < N; i++) begin
      adr_a_s[i]   = m_adr[i*18 +: 18];
      write_a_s[i] = m_write[i];
      sel_a_s[i]   = m_sel[i*2 +: 2];
      wdata_a_s[i] = m_wdata[i*16 +: 16];
    end
  end

  // Winner search from ptr upward with wrap. In fixed priority ptr stays 0,
  // so the same search becomes lowest index first.
  always_comb begin
    int idx_v;
    idx_v       = 0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      idx_v = int'(ptr_r) + i;
      if (idx_v >= N) begin
        idx_v = idx_v - N;
      end else begin
        idx_v = idx_v + 0;
      end
      if (!win_found_s && m_req[GW'(idx_v)]) begin
        win_found_s = 1'b1;
        win_idx_s   = GW'(idx_v);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign nxt_ptr_s = '0;
`else
  assign nxt_ptr_s = (grant_r == GW'(N - 1)) ? '0 : grant_r + GW'(1);
`endif

  assign wd_inc_s = wd_cnt_r + 16'd1;

  // Next-state and next-register values for the IDLE/BUSY/ABORT machine
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    grant_s   = grant_r;
    wd_cnt_s  = wd_cnt_r;
    s_req_s   = s_req_r;
    s_adr_s   = s_adr_r;
    s_write_s = s_write_r;
    s_sel_s   = s_sel_r;
    s_wdata_s = s_wdata_r;
    m_err_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          s_adr_s   = adr_a_s[win_idx_s];
          s_write_s = write_a_s[win_idx_s];
          s_sel_s   = sel_a_s[win_idx_s];
          s_wdata_s = wdata_a_s[win_idx_s];
          s_req_s   = 1'b1;
          grant_s   = win_idx_s;
          wd_cnt_s  = 16'd0;
          state_s   = ST_BUSY;
        end else begin
          s_req_s   = 1'b0;
        end
      end
      ST_BUSY: begin
        // An ack in the expiry cycle wins over the watchdog
        if (s_ack) begin
          s_req_s = 1'b0;
          ptr_s   = nxt_ptr_s;
          state_s = ST_IDLE;
        end else if (wd_inc_s == 16'(TIMEOUT)) begin
          s_req_s = 1'b0;
          ptr_s   = nxt_ptr_s;
          state_s = ST_ABORT;
          for (int i = 0; i < N; i++) begin
            m_err_s[i] = (grant_r == GW'(i));
          end
        end else begin
          wd_cnt_s = wd_inc_s;
        end
      end
      ST_ABORT: begin
        state_s = ST_IDLE;
      end
      default: begin
        s_req_s = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and slave-port registers; reset clears s_req immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      grant_r   <= '0;
      wd_cnt_r  <= 16'd0;
      s_req_r   <= 1'b0;
      s_adr_r   <= 18'd0;
      s_write_r <= 1'b0;
      s_sel_r   <= 2'd0;
      s_wdata_r <= 16'd0;
      m_err_r   <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      grant_r   <= grant_s;
      wd_cnt_r  <= wd_cnt_s;
      s_req_r   <= s_req_s;
      s_adr_r   <= s_adr_s;
      s_write_r <= s_write_s;
      s_sel_r   <= s_sel_s;
      s_wdata_r <= s_wdata_s;
      m_err_r   <= m_err_s;
      busy_r    <= (state_s == ST_BUSY);
    end
  end

  // Acknowledge is routed back to the granted master only while BUSY
  always_comb begin
    m_ack = '0;
    for (int i = 0; i < N; i++) begin
      m_ack[i] = (state_r == ST_BUSY) && s_ack && (grant_r == GW'(i));
    end
  end

  assign m_rdata = s_rdata;
  assign m_err   = m_err_r;
  assign s_req   = s_req_r;
  assign s_adr   = s_adr_r;
  assign s_write = s_write_r;
  assign s_sel   = s_sel_r;
  assign s_wdata = s_wdata_r;
  assign grant   = grant_r;
  assign busy    = busy_r;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing the single 18-bit-address, 16-bit-data memory port among `N` bus masters, such as the lights controller DMA, the CPU and a debug loader. It sits between the masters' `m_*` request ports and the memory controller's slave port. It serialises one transfer at a time, registers all slave-side outputs, and routes the acknowledge back to the winning master. It also contains a watchdog that aborts transfers the memory never acknowledges.

## Interface
Parameters:
- `N`, 3: number of masters (2–8); master 0 is the lowest index.
- `TIMEOUT`, 255: maximum cycles in BUSY without `s_ack` before abort (1–65535).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m_req`  in  N  per-master request level.
- `m_adr`  in  N*18  master i address in bits [i*18+17:i*18].
- `m_write`  in  N  per-master write flag.
- `m_sel`  in  N*2  per-master byte lanes.
- `m_wdata`  in  N*16  per-master write data.
- `m_ack`  out  N  one-cycle completion pulse to the granted master.
- `m_err`  out  N  one-cycle timeout-abort pulse to the granted master.
- `m_rdata`  out  16  `s_rdata` broadcast to all masters; valid only with `m_ack`.
- `s_req`, `s_adr[17:0]`, `s_write`, `s_sel[1:0]`, `s_wdata[15:0]`  out  slave port, all registered.
- `s_ack`  in  1  slave completion; `s_rdata` valid in the same cycle.
- `s_rdata`  in  16  slave read data.
- `grant`  out  $clog2(N)  index of the current or last granted master (debug).
- `busy`  out  1  high while in BUSY.

## Operation
- The state machine has three states: IDLE, BUSY and ABORT.
- IDLE:
  - If any `m_req` bit is set, pick the winner by round-robin, searching from `ptr` upward and wrapping at N.
  - Latch the winner's adr/write/sel/wdata into the `s_*` registers, set `s_req`=1 and `grant`=winner, then go to BUSY.
  - If no `m_req` bit is set, `s_req`=0 and `s_adr`/`s_wdata` hold their last values.
- BUSY:
  - `m_ack[grant]` = `s_ack` (combinational), and `m_rdata` = `s_rdata`.
  - On `s_ack`: clear `s_req`, set `ptr` = (grant+1) mod N, go to IDLE.
  - Otherwise increment the watchdog counter. At count == `TIMEOUT`: clear `s_req`, pulse `m_err[grant]`, advance `ptr`, go to ABORT.
- ABORT: one dead cycle, then IDLE. `s_ack` arriving in ABORT is ignored and produces no `m_ack`.
- Requests are level-sensitive: a master that holds `m_req` high after `m_ack` gets another transfer with whatever address it presents in the cycle after the ack.
- A master dropping `m_req` while granted does not cancel the transfer; its `m_ack` still pulses.
- Master inputs are sampled only in IDLE. Changes during BUSY are ignored.
- The watchdog counter is 16 bits and clears when entering BUSY.

## Timing
- Reset values:
  - `s_req`=0, `s_adr`=0, `s_write`=0, `s_sel`=0, `s_wdata`=0.
  - `grant`=0, `busy`=0, `ptr`=0.
  - `m_ack`=0, `m_err`=0 (`m_rdata` follows `s_rdata`).
  - State = IDLE.
- Reset mid-transfer drops `s_req` asynchronously. Any `s_ack` in flight is discarded.
- Latency: with `m_req` high at edge k in IDLE, `s_req` and `s_adr` are valid after edge k. With a zero-wait slave acking in that cycle, `m_ack` pulses in the same cycle and the state is IDLE after edge k+1.
- Back-to-back minimum is 2 cycles per transfer: one IDLE cycle and at least one BUSY cycle.
- `s_ack` in the same cycle as the watchdog reaching `TIMEOUT`: the ack wins, giving a normal completion with no `m_err`.
- `s_ack` while IDLE is ignored.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`:
  - Defined: round-robin is replaced by fixed priority, where the lowest set index in `m_req` always wins and `ptr` is unused (held at 0).
  - Undefined: round-robin as described above.
  - All other behaviour is identical in both cases.

## Test plan
- Single master 1 with `m_adr`=0x00123 and a slave acking in the first BUSY cycle with rdata 0xBEEF: `s_adr`=0x00123, one `m_ack[1]` pulse with `m_rdata`=0xBEEF, `grant`=1, IDLE one cycle later.
- All three masters holding `m_req` for 6 transfers: grant order 0,1,2,0,1,2 (round-robin). With `MEM_ARB_FIXED_PRIO_EN`: grant order 0,0,0,0,0,0.
- Slave never acks with `TIMEOUT`=4: after 4 BUSY cycles, `m_err[grant]` pulses once, `s_req`=0, one ABORT cycle, then the next master is granted.
- `s_ack` arriving in the exact watchdog-expiry cycle: `m_ack` pulses and `m_err` stays 0.
- Master 2 drops `m_req` after being granted, with a 3-cycle slave: `m_ack[2]` still pulses, then the arbiter idles.
- `rst` asserted asynchronously mid-BUSY: `s_req` falls before the next clock edge. A late `s_ack` after reset release produces no `m_ack`.
